// File: rtl/ch77_mon_pkg.sv
// rtl/ch77_mon_pkg.sv - shared constants and helpers for the channel-77 monitor reader
package ch77_mon_pkg;

    typedef logic [3:0] tp_t;

    localparam tp_t TP_SEL       = 4'd1;
    localparam tp_t TP_T05       = 4'd5;
    localparam tp_t TP_RD_FIRST  = 4'd7;
    localparam tp_t TP_RD_LAST   = 4'd8;
    localparam tp_t TP_CLR_FIRST = 4'd9;
    localparam tp_t TP_CLR_LAST  = 4'd10;
    localparam tp_t TP_ADDR_LAST = 4'd11;
    localparam tp_t TP_DESEL     = 4'd12;

    // Alarm bit positions within the captured word (bit 0 = MDT01).
    localparam int PAR_E       = 0;
    localparam int PAR_F       = 1;
    localparam int TC_TRAP     = 2;
    localparam int RUPT_LOCK   = 3;
    localparam int NIGHT_WATCH = 4;
    localparam int VFAIL       = 5;
    localparam int CTR_FAIL    = 6;
    localparam int SCL_FAIL    = 7;
    localparam int SCL_DBL     = 8;

    typedef logic [1:0] mon_state_t;

    localparam mon_state_t ST_IDLE  = 2'd0;
    localparam mon_state_t ST_CYCLE = 2'd1;
    localparam mon_state_t ST_RESP  = 2'd2;

    function automatic logic tp_in(input tp_t tp, input tp_t lo, input tp_t hi);
        return (tp >= lo) && (tp <= hi);
    endfunction

endpackage

// File: rtl/ch77_monitor_reader_tp_gen.sv
// rtl/ch77_monitor_reader_tp_gen.sv - monitor timepulse sequencer (tp 1..12, TP_CYCLES clocks each)
module mon_tp_gen
    import ch77_mon_pkg::*;
#(
    parameter int TP_CYCLES = 4
) (
    input  logic SIM_CLK,
    input  logic SIM_RST,
    input  logic start,
    output tp_t  tp,
    output tp_t  tp_next,
    output logic tp_end,
    output logic done
);

    localparam int SW = $clog2(TP_CYCLES);
    localparam logic [SW-1:0] SUB_LAST = SW'(TP_CYCLES - 1);

    logic [SW-1:0] sub;

    // tp == 0 means no cycle in progress.
    assign tp_end = (tp != 4'd0) && (sub == SUB_LAST);
    assign done   = tp_end && (tp == TP_DESEL);

    always_comb begin
        tp_next = tp;
        if (start) begin
            tp_next = TP_SEL;
        end else if (tp_end) begin
            tp_next = done ? 4'd0 : tp + 4'd1;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            tp  <= 4'd0;
            sub <= '0;
        end else begin
            tp <= tp_next;
            if (start || tp_end) begin
                sub <= '0;
            end else if (tp != 4'd0) begin
                sub <= sub + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ch77_monitor_reader.sv
// rtl/ch77_monitor_reader.sv - monitor-bus initiator reading (and optionally clearing) channel 77
module ch77_monitor_reader
    import ch77_mon_pkg::*;
#(
    parameter int         TP_CYCLES     = 4,
    parameter logic [5:0] ADDR          = 6'o77,
    parameter int         POLL_INTERVAL = 0
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       req_valid,
    input  logic       req_clear,
    output logic       req_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] rsp_word,
    output logic       rsp_cleared,
    output logic       rsp_auto,
    output logic       MWL01,
    output logic       MWL02,
    output logic       MWL03,
    output logic       MWL04,
    output logic       MWL05,
    output logic       MWL06,
    output logic       MT01,
    output logic       MT05,
    output logic       MT12,
    output logic       MWSG,
    output logic       MRCH,
    output logic       MWCH,
    input  logic       MDT01,
    input  logic       MDT02,
    input  logic       MDT03,
    input  logic       MDT04,
    input  logic       MDT05,
    input  logic       MDT06,
    input  logic       MDT07,
    input  logic       MDT08,
    input  logic       MDT09
);

    localparam logic [31:0] POLL_LAST = (POLL_INTERVAL > 0) ? 32'(POLL_INTERVAL - 1) : 32'd0;

    mon_state_t  state;
    tp_t         tp;
    tp_t         tp_next;
    logic        tp_end;
    logic        done;
    logic        start;
    logic        poll_expire;
    logic [31:0] poll_cnt;
    logic        clr_q;
    logic        auto_q;
    logic [8:0]  cap_q;
    logic [8:0]  mdt;
    logic [5:0]  mwl_q;

    assign mdt = {MDT09, MDT08, MDT07, MDT06, MDT05, MDT04, MDT03, MDT02, MDT01};

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign poll_expire = (POLL_INTERVAL > 0) && (state == ST_IDLE) && (poll_cnt == POLL_LAST);
    // A host request arriving on the expiry clock takes the slot as a non-auto cycle.
    assign start       = (state == ST_IDLE) && (req_valid || poll_expire);

    assign {MWL06, MWL05, MWL04, MWL03, MWL02, MWL01} = mwl_q;

    mon_tp_gen #(
        .TP_CYCLES(TP_CYCLES)
    ) u_tp_gen (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .start   (start),
        .tp      (tp),
        .tp_next (tp_next),
        .tp_end  (tp_end),
        .done    (done)
    );

    // Strobes are decoded from the next timepulse so they leave registers aligned to tp boundaries.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            mwl_q <= 6'd0;
            MT01  <= 1'b0;
            MT05  <= 1'b0;
            MT12  <= 1'b0;
            MWSG  <= 1'b0;
            MRCH  <= 1'b0;
            MWCH  <= 1'b0;
        end else begin
            mwl_q <= tp_in(tp_next, TP_SEL, TP_ADDR_LAST) ? ADDR : 6'd0;
            MT01  <= (tp_next == TP_SEL);
            MWSG  <= (tp_next == TP_SEL);
            MT05  <= (tp_next == TP_T05);
            MT12  <= (tp_next == TP_DESEL);
            MRCH  <= tp_in(tp_next, TP_RD_FIRST, TP_RD_LAST);
            MWCH  <= clr_q && tp_in(tp_next, TP_CLR_FIRST, TP_CLR_LAST);
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state       <= ST_IDLE;
            clr_q       <= 1'b0;
            auto_q      <= 1'b0;
            cap_q       <= 9'd0;
            rsp_word    <= 9'd0;
            rsp_cleared <= 1'b0;
            rsp_auto    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_CYCLE;
                        clr_q  <= req_valid && req_clear;
                        auto_q <= !req_valid;
                    end
                end
                ST_CYCLE: begin
                    if ((tp == TP_RD_LAST) && tp_end) begin
                        cap_q <= mdt;
                    end
                    if (done) begin
                        state       <= ST_RESP;
                        rsp_word    <= cap_q;
                        rsp_cleared <= clr_q;
                        rsp_auto    <= auto_q;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The poll timer only advances while idle and restarts whenever any cycle begins.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            poll_cnt <= 32'd0;
        end else if ((POLL_INTERVAL > 0) && (state == ST_IDLE)) begin
            poll_cnt <= start ? 32'd0 : poll_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ch77_monitor_reader.sv
// tb/tb_ch77_monitor_reader.sv - directed self-checking bench for ch77_monitor_reader
module tb_ch77_monitor_reader;

    logic       SIM_CLK;
    logic       SIM_RST;
    logic       req_valid, req_clear, rsp_ready;
    logic       req_ready, rsp_valid, rsp_cleared, rsp_auto;
    logic [8:0] rsp_word;
    logic       MWL01, MWL02, MWL03, MWL04, MWL05, MWL06;
    logic       MT01, MT05, MT12, MWSG, MRCH, MWCH;
    wire  [8:0] mdt;

    logic       p_req_valid, p_req_clear, p_rsp_ready;
    logic       p_req_ready, p_rsp_valid, p_rsp_cleared, p_rsp_auto;
    logic [8:0] p_rsp_word;
    logic       p_MWL01, p_MWL02, p_MWL03, p_MWL04, p_MWL05, p_MWL06;
    logic       p_MT01, p_MT05, p_MT12, p_MWSG, p_MRCH, p_MWCH;
    wire  [8:0] p_mdt;

    logic [8:0] alarm, alarm_val;
    logic       alarm_load;

    int n_chk = 0;
    int n_err = 0;

    wire [12:0] vec   = {MWL06, MWL05, MWL04, MWL03, MWL02, MWL01,
                         MT01, MT05, MT12, MWSG, MRCH, MWCH, rsp_valid};
    wire [11:0] bus   = vec[12:1];
    wire [12:0] p_vec = {p_MWL06, p_MWL05, p_MWL04, p_MWL03, p_MWL02, p_MWL01,
                         p_MT01, p_MT05, p_MT12, p_MWSG, p_MRCH, p_MWCH, p_rsp_valid};

    always @(posedge SIM_CLK) begin
        if (alarm_load) alarm <= alarm_val;
        else if (MWCH) alarm <= 9'h000;
    end
    assign mdt   = MRCH ? alarm : 9'h000;
    assign p_mdt = p_MRCH ? 9'h03C : 9'h000;

    ch77_monitor_reader dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .req_valid(req_valid), .req_clear(req_clear), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
        .rsp_cleared(rsp_cleared), .rsp_auto(rsp_auto),
        .MWL01(MWL01), .MWL02(MWL02), .MWL03(MWL03), .MWL04(MWL04), .MWL05(MWL05), .MWL06(MWL06),
        .MT01(MT01), .MT05(MT05), .MT12(MT12), .MWSG(MWSG), .MRCH(MRCH), .MWCH(MWCH),
        .MDT01(mdt[0]), .MDT02(mdt[1]), .MDT03(mdt[2]), .MDT04(mdt[3]), .MDT05(mdt[4]),
        .MDT06(mdt[5]), .MDT07(mdt[6]), .MDT08(mdt[7]), .MDT09(mdt[8])
    );

    ch77_monitor_reader #(.POLL_INTERVAL(100)) dut_p (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .req_valid(p_req_valid), .req_clear(p_req_clear), .req_ready(p_req_ready),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_word(p_rsp_word),
        .rsp_cleared(p_rsp_cleared), .rsp_auto(p_rsp_auto),
        .MWL01(p_MWL01), .MWL02(p_MWL02), .MWL03(p_MWL03), .MWL04(p_MWL04), .MWL05(p_MWL05), .MWL06(p_MWL06),
        .MT01(p_MT01), .MT05(p_MT05), .MT12(p_MT12), .MWSG(p_MWSG), .MRCH(p_MRCH), .MWCH(p_MWCH),
        .MDT01(p_mdt[0]), .MDT02(p_mdt[1]), .MDT03(p_mdt[2]), .MDT04(p_mdt[3]), .MDT05(p_mdt[4]),
        .MDT06(p_mdt[5]), .MDT07(p_mdt[6]), .MDT08(p_mdt[7]), .MDT09(p_mdt[8])
    );

    initial begin
        SIM_CLK = 1'b0;
        forever #5 SIM_CLK = ~SIM_CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic load_alarm(input logic [8:0] v);
        alarm_val  = v;
        alarm_load = 1'b1;
        tick();
        alarm_load = 1'b0;
    endtask

    // Hand-derived strobe windows for TP_CYCLES=4, clock n counted from the acceptance edge.
    function automatic logic [12:0] exp_vec(input int n, input logic clr);
        logic [5:0] mwl;
        logic       mt01, mt05, mt12, mrch, mwch;
        mwl  = (n >= 1 && n <= 44) ? 6'o77 : 6'o00;
        mt01 = (n >= 1 && n <= 4);
        mt05 = (n >= 17 && n <= 20);
        mt12 = (n >= 45 && n <= 48);
        mrch = (n >= 25 && n <= 32);
        mwch = clr && (n >= 33 && n <= 40);
        return {mwl, mt01, mt05, mt12, mt01, mrch, mwch, 1'b0};
    endfunction

    // Ends in clock 49 with the response presented; the caller owns the handshake.
    task automatic run_read(input string nm, input logic clr, input logic [8:0] exp_word);
        chk($sformatf("%s_req_ready", nm), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_clear = clr;
        tick();
        req_valid = 1'b0;
        req_clear = 1'b0;
        for (int n = 1; n <= 48; n++) begin
            chk($sformatf("%s_bus@%0d", nm, n), {19'd0, vec}, {19'd0, exp_vec(n, clr)});
            tick();
        end
        chk($sformatf("%s_rsp@49", nm),
            {7'd0, rsp_valid, rsp_word, rsp_cleared, rsp_auto, req_ready, bus},
            {7'd0, 1'b1, exp_word, clr, 1'b0, 1'b0, 12'd0});
    endtask

    initial begin
        logic [12:0] seen;
        int          k;
        int          n;

        SIM_RST = 1'b1;
        req_valid = 1'b0; req_clear = 1'b0; rsp_ready = 1'b1;
        p_req_valid = 1'b0; p_req_clear = 1'b0; p_rsp_ready = 1'b1;
        alarm_val = 9'h000; alarm_load = 1'b1;
        tick();
        tick();
        SIM_RST = 1'b0;
        alarm_load = 1'b0;

        chk("reset_outputs", {6'd0, req_ready, rsp_valid, rsp_word, rsp_cleared, rsp_auto, bus},
            {6'd0, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 12'd0});
        seen = '0;
        for (int i = 0; i < 200; i++) begin
            seen |= vec;
            tick();
        end
        chk("reset_quiet_200", {19'd0, seen}, 32'd0);

        load_alarm(9'h0A5);
        run_read("read_a5", 1'b0, 9'h0A5);
        tick();

        load_alarm(9'h101);
        run_read("clr_101", 1'b1, 9'h101);
        tick();
        chk("alarm_cleared", {23'd0, alarm}, 32'd0);
        run_read("after_clr", 1'b0, 9'h000);
        tick();

        load_alarm(9'h15A);
        rsp_ready = 1'b0;
        run_read("bp", 1'b0, 9'h15A);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            chk($sformatf("bp_hold@%0d", i), {19'd0, rsp_valid, rsp_word, req_ready, MT01, MWSG},
                {19'd0, 1'b1, 9'h15A, 1'b0, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            seen |= vec;
            tick();
        end
        chk("bp_req_dropped", {19'd0, seen}, 32'd0);
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);

        load_alarm(9'h1F0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        chk("rst_mid_tp6", {30'd0, MT05, MRCH}, 32'd0);
        SIM_RST = 1'b1;
        tick();
        SIM_RST = 1'b0;
        chk("rst_mid_bus0", {18'd0, req_ready, vec}, {18'd0, 1'b1, 13'd0});
        seen = '0;
        for (int i = 0; i < 60; i++) begin
            seen |= vec;
            tick();
        end
        chk("rst_mid_no_rsp", {19'd0, seen}, 32'd0);
        run_read("after_rst", 1'b0, 9'h1F0);
        tick();

        SIM_RST = 1'b1;
        tick();
        SIM_RST = 1'b0;
        k = 0;
        while (!p_MT01 && k < 300) begin
            tick();
            k++;
        end
        chk("poll_first_start", k, 32'd100);
        chk("poll_bus@1", {19'd0, p_vec}, {19'd0, exp_vec(1, 1'b0)});
        n = 1;
        seen = '0;
        while (!p_rsp_valid && n < 100) begin
            seen |= p_vec;
            tick();
            n++;
        end
        chk("poll_latency", n, 32'd49);
        chk("poll_no_mwch", {31'd0, seen[1]}, 32'd0);
        chk("poll_rsp", {20'd0, p_rsp_word, p_rsp_cleared, p_rsp_auto, p_req_ready},
            {20'd0, 9'h03C, 1'b0, 1'b1, 1'b0});

        tick();
        seen = '0;
        for (int i = 0; i < 99; i++) begin
            seen |= p_vec;
            tick();
        end
        chk("poll_no_early", {19'd0, seen}, 32'd0);
        p_req_valid = 1'b1;
        tick();
        p_req_valid = 1'b0;
        chk("host_wins_start", {19'd0, p_vec}, {19'd0, exp_vec(1, 1'b0)});
        n = 1;
        while (!p_rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("host_wins_latency", n, 32'd49);
        chk("host_wins_rsp", {21'd0, p_rsp_word, p_rsp_cleared, p_rsp_auto},
            {21'd0, 9'h03C, 1'b0, 1'b0});
        tick();
        k = 0;
        while (!p_MT01 && k < 300) begin
            tick();
            k++;
        end
        chk("poll_restart", k, 32'd100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
